// File: rtl/ts_link_pkg.sv
// rtl/ts_link_pkg.sv - shared constants for the trigger-scintillator link TX pattern path
package ts_link_pkg;

    // Comma idle word: K28.5 in the low byte, K flag set on that byte only
    localparam logic [15:0] IDLE_D_DEF = 16'h50BC;
    localparam logic [1:0]  IDLE_K_DEF = 2'b01;

    // Pattern word is {k[1:0], d[15:0]}
    localparam int PAT_W = 18;

    // Playback FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;

endpackage

// File: rtl/ts_pattern_ram.sv
// rtl/ts_pattern_ram.sv - single-clock simple dual-port pattern RAM, registered read-first
module ts_pattern_ram #(
    parameter int AW = 6,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write and registered read share one edge; the read sees the pre-write contents
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ts_tx_pattern.sv
// rtl/ts_tx_pattern.sv - link TX pattern generator: plays a preloaded buffer once or in a loop
module ts_tx_pattern
    import ts_link_pkg::*;
#(
    parameter int          PAT_AW = 6,
    parameter logic [15:0] IDLE_D = IDLE_D_DEF,
    parameter logic [1:0]  IDLE_K = IDLE_K_DEF
) (
    input  logic              tx_clk,
    input  logic              reset,
    input  logic              wr_stb,
    input  logic [PAT_AW-1:0] wr_addr,
    input  logic [17:0]       wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [PAT_AW-1:0] length,
    output logic [15:0]       tx_d,
    output logic [1:0]        tx_k,
    output logic              busy,
    output logic              done,
    output logic [31:0]       pass_count
);

    logic [1:0]        state_q, state_d;
    logic [PAT_AW-1:0] len_q, len_d;
    logic              loop_q, loop_d;
    logic              stop_q, stop_d;
    logic [PAT_AW-1:0] rd_addr_q, rd_addr_d;
    logic [PAT_AW-1:0] rd_idx_q, rd_idx_d;
    logic              end_q, end_d;
    logic [15:0]       tx_d_q, tx_d_d;
    logic [1:0]        tx_k_q, tx_k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       pass_q, pass_d;

    logic [PAT_W-1:0]  rd_data;
    logic [PAT_AW-1:0] next_addr;
    logic              stop_eff;

    ts_pattern_ram #(
        .AW (PAT_AW),
        .DW (PAT_W)
    ) u_ram (
        .clk   (tx_clk),
        .we    (wr_stb),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr_q),
        .rdata (rd_data)
    );

    // Next-state: rd_idx_q tracks which entry rd_data holds, so a pass ends when it equals len_q
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        loop_d    = loop_q;
        stop_d    = stop_q;
        rd_addr_d = rd_addr_q;
        rd_idx_d  = rd_idx_q;
        pass_d    = pass_q;
        tx_d_d    = IDLE_D;
        tx_k_d    = IDLE_K;
        end_d     = 1'b0;
        done_d    = end_q;
        stop_eff  = stop_q | stop;
        next_addr = (rd_addr_q == len_q) ? '0 : rd_addr_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PRIME;
                    len_d     = length;
                    loop_d    = loop;
                    stop_d    = 1'b0;
                    rd_addr_d = '0;
                end
            end
            ST_PRIME: begin
                stop_d    = stop_eff;
                rd_idx_d  = rd_addr_q;
                rd_addr_d = next_addr;
                state_d   = ST_PLAY;
            end
            ST_PLAY: begin
                stop_d    = stop_eff;
                tx_d_d    = rd_data[15:0];
                tx_k_d    = rd_data[17:16];
                rd_idx_d  = rd_addr_q;
                rd_addr_d = next_addr;
                if (rd_idx_q == len_q) begin
                    pass_d = pass_q + 32'd1;
                    if (!loop_q || stop_eff) begin
                        state_d = ST_IDLE;
                        end_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stay busy while the final word of a pass is still on the wire
        busy_d = (state_d != ST_IDLE) | end_d;
    end

    // State and output registers; RAM contents are deliberately untouched by reset
    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
            rd_addr_q <= '0;
            rd_idx_q  <= '0;
            end_q     <= 1'b0;
            tx_d_q    <= IDLE_D;
            tx_k_q    <= IDLE_K;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            stop_q    <= stop_d;
            rd_addr_q <= rd_addr_d;
            rd_idx_q  <= rd_idx_d;
            end_q     <= end_d;
            tx_d_q    <= tx_d_d;
            tx_k_q    <= tx_k_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign tx_d       = tx_d_q;
    assign tx_k       = tx_k_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_count = pass_q;

endmodule

// File: tb/tb_ts_tx_pattern.sv
// tb/tb_ts_tx_pattern.sv - self-checking bench for ts_tx_pattern
module tb_ts_tx_pattern;

    logic        tx_clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_stb = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [17:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [5:0]  length = '0;
    logic [15:0] tx_d;
    logic [1:0]  tx_k;
    logic        busy;
    logic        done;
    logic [31:0] pass_count;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    ts_tx_pattern #(
        .PAT_AW (6),
        .IDLE_D (16'h50BC),
        .IDLE_K (2'b01)
    ) dut (
        .tx_clk     (tx_clk),
        .reset      (reset),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .length     (length),
        .tx_d       (tx_d),
        .tx_k       (tx_k),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: since a start, word k of the playback stream is entry k mod (len+1),
    // fetched from the buffer one edge before it is driven (read-first)
    logic [17:0] m_mem [64];
    logic        m_run = 1'b0;
    logic        m_tail = 1'b0;
    logic        m_stop = 1'b0;
    logic        m_loop = 1'b0;
    int          m_len = 0;
    int          m_t = 0;
    int          m_idx = 0;
    logic [17:0] m_pre = '0;
    logic [31:0] m_pass = '0;
    logic [15:0] e_d = 16'h50BC;
    logic [1:0]  e_k = 2'b01;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
    end

    always @(posedge tx_clk) begin
        e_done = 1'b0;
        if (reset) begin
            m_run  = 1'b0;
            m_tail = 1'b0;
            m_pass = '0;
            e_d    = 16'h50BC;
            e_k    = 2'b01;
            e_busy = 1'b0;
        end else if (m_run) begin
            if (stop) m_stop = 1'b1;
            m_t = m_t + 1;
            e_busy = 1'b1;
            if (m_t == 1) begin
                e_d = 16'h50BC;
                e_k = 2'b01;
            end else begin
                e_d = m_pre[15:0];
                e_k = m_pre[17:16];
                m_idx = (m_t - 2) % (m_len + 1);
                if (m_idx == m_len) begin
                    m_pass = m_pass + 32'd1;
                    if (!m_loop || m_stop) begin
                        m_run  = 1'b0;
                        m_tail = 1'b1;
                    end
                end
            end
            m_pre = m_mem[(m_t - 1) % (m_len + 1)];
        end else begin
            e_d    = 16'h50BC;
            e_k    = 2'b01;
            e_done = m_tail;
            m_tail = 1'b0;
            e_busy = 1'b0;
            if (start) begin
                m_run  = 1'b1;
                m_t    = 0;
                m_len  = int'(length);
                m_loop = loop;
                m_stop = 1'b0;
                e_busy = 1'b1;
            end
        end
        if (wr_stb) m_mem[wr_addr] = wr_data;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge tx_clk) begin
        if (cmp_en) begin
            check("tx_d", {16'h0, tx_d}, {16'h0, e_d});
            check("tx_k", {30'h0, tx_k}, {30'h0, e_k});
            check("busy", {31'h0, busy}, {31'h0, e_busy});
            check("done", {31'h0, done}, {31'h0, e_done});
            check("pass_count", pass_count, m_pass);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge tx_clk);
    endtask

    task automatic wr(input int a, input logic [17:0] d);
        wr_stb  = 1'b1;
        wr_addr = a[5:0];
        wr_data = d;
        tick(1);
        wr_stb  = 1'b0;
    endtask

    task automatic go(input logic [5:0] len, input logic lp);
        length = len;
        loop   = lp;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
    endtask

    initial begin
        logic [17:0] w;
        tick(3);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // Idle after reset
        tick(5);
        check("rst_tx_d", {16'h0, tx_d}, 32'h50BC);
        check("rst_tx_k", {30'h0, tx_k}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_pass", pass_count, 32'h0);

        // One-shot of four words
        for (int i = 0; i < 4; i++) begin
            w = {2'b00, 16'h1000 + 16'(i)};
            wr(i, w);
        end
        go(6'd3, 1'b0);
        tick(2);
        check("os_first", {16'h0, tx_d}, 32'h1000);
        check("os_busy", {31'h0, busy}, 32'h1);
        tick(3);
        check("os_last", {16'h0, tx_d}, 32'h1003);
        check("os_nodone", {31'h0, done}, 32'h0);
        tick(1);
        check("os_idle", {16'h0, tx_d}, 32'h50BC);
        check("os_done", {31'h0, done}, 32'h1);
        check("os_pass", pass_count, 32'd1);
        tick(1);
        check("os_done_pulse", {31'h0, done}, 32'h0);

        // Single-word continuous loop, then graceful stop
        wr(0, {2'b10, 16'hA5A5});
        go(6'd0, 1'b1);
        tick(5);
        check("l0_word", {16'h0, tx_d}, 32'hA5A5);
        check("l0_k", {30'h0, tx_k}, 32'h2);
        check("l0_pass", pass_count, 32'd5);
        tick(5);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        check("l0_done", {31'h0, done}, 32'h1);
        check("l0_pass_end", pass_count, 32'd11);
        tick(3);

        // Full-depth loop stopped mid-pass
        for (int i = 0; i < 64; i++) begin
            w = {2'(i % 4), 16'h2000 + 16'(i)};
            wr(i, w);
        end
        go(6'd63, 1'b1);
        tick(21);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("l63_e20", {16'h0, tx_d}, 32'h2014);
        tick(43);
        check("l63_e63", {16'h0, tx_d}, 32'h203F);
        check("l63_k63", {30'h0, tx_k}, 32'h3);
        tick(1);
        check("l63_idle", {16'h0, tx_d}, 32'h50BC);
        check("l63_done", {31'h0, done}, 32'h1);
        check("l63_pass", pass_count, 32'd12);
        tick(2);

        // Write during read of the same entry, and start while busy
        go(6'd7, 1'b1);
        tick(3);
        length = 6'd0;
        loop   = 1'b0;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(1);
        wr(5, {2'b00, 16'hBEEF});
        tick(1);
        check("wr_old", {16'h0, tx_d}, 32'h2005);
        tick(8);
        check("wr_new", {16'h0, tx_d}, 32'hBEEF);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);
        check("wr_done", {31'h0, done}, 32'h1);
        check("wr_pass", pass_count, 32'd14);
        tick(2);

        // Reset mid-loop, RAM survives
        go(6'd7, 1'b1);
        tick(4);
        check("rs_e2", {16'h0, tx_d}, 32'h2002);
        reset = 1'b1;
        tick(1);
        check("rs_idle", {16'h0, tx_d}, 32'h50BC);
        check("rs_busy", {31'h0, busy}, 32'h0);
        check("rs_pass", pass_count, 32'h0);
        tick(1);
        reset = 1'b0;
        tick(1);
        go(6'd7, 1'b0);
        tick(2);
        check("rs_replay0", {16'h0, tx_d}, 32'h2000);
        tick(5);
        check("rs_replay5", {16'h0, tx_d}, 32'hBEEF);
        tick(3);
        check("rs_done", {31'h0, done}, 32'h1);
        check("rs_pass_end", pass_count, 32'd1);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ts_tx_pattern.md
# ts_tx_pattern

Transmit-side pattern generator for the trigger-scintillator link: the TX counterpart of the RX spy capture. Software preloads a pattern buffer of 16-bit words with per-byte K flags. On command, the block plays the buffer onto the link transmit data/K inputs once or continuously. Between patterns it sends the comma idle word. It sits between the register-bus decode and the TX side of the per-link transceiver wrapper, one instance per link, entirely in the link TX clock domain.

## Interface
- PAT_AW, 6, pattern address width; depth = 2**PAT_AW entries
- IDLE_D, 16'h50BC, idle data word (K28.5 in low byte)
- IDLE_K, 2'b01, idle K flags
- tx_clk  in  1  link TX clock; the only clock
- reset  in  1  synchronous, active-high
- wr_stb  in  1  single-cycle pattern write strobe
- wr_addr  in  PAT_AW  pattern entry index
- wr_data  in  18  {k[1:0], d[15:0]}
- start  in  1  single-cycle start command
- stop  in  1  single-cycle graceful stop
- loop  in  1  continuous playback when high; sampled with start
- length  in  PAT_AW  last entry index; pattern = length+1 words (1..2**PAT_AW)
- tx_d  out  16  transmit data, registered
- tx_k  out  2  transmit K flags, registered
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse, end of one-shot or stopped playback
- pass_count  out  32  completed passes since reset

## Operation
- States: IDLE, PRIME, PLAY.
- IDLE: tx_d=IDLE_D, tx_k=IDLE_K. When start=1, latch length into len_r and loop into loop_r, clear stop_r, set rd_addr=0, then go to PRIME. start is ignored in PRIME and PLAY.
- PRIME: one cycle to cover RAM read latency. rd_addr advances to 1, or stays at 0 when len_r=0. Output stays idle. Then go to PLAY.
- PLAY: tx_d/tx_k come from RAM entry rd_addr−1 (pipelined). Addresses run 0..len_r.
- Pass completion: the cycle entry len_r is driven is the last word of a pass, and pass_count increments on that cycle. If loop_r=1 and stop_r=0, entry 0 follows in the next cycle with no idle gap. Otherwise go to IDLE: the idle word appears the next cycle and done pulses with it.
- stop=1 in PLAY or PRIME sets stop_r, so the current pass completes and then the block goes idle. stop in IDLE is ignored. If start and stop arrive in the same IDLE cycle, start is taken and stop is dropped.
- pass_count wraps 32'hFFFFFFFF -> 0 and is cleared only by reset.
- Writes are accepted in every state, including during playback. On a same-cycle write and read of one address, the read returns the old data (read-first).
- Reset mid-playback: outputs go to idle on the next edge and the state returns to IDLE. Pattern RAM contents are not cleared.
- Reset values: tx_d=IDLE_D, tx_k=IDLE_K, busy=0, done=0, pass_count=0.

## Timing
- start sampled at edge N: busy=1 from N+1, entry 0 on tx_d from N+2, entry i at N+2+i.
- One-shot: the last word is at N+2+len_r, and idle plus done appear at N+3+len_r.
- Loop: the pass period is exactly len_r+1 cycles, with no gaps.
- A write at edge W becomes visible to a read issued at edge W+1 or later.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- Package ts_link_pkg holds:
  - the IDLE_D/IDLE_K defaults
  - the 18-bit pattern word width
  - the state encoding (IDLE, PRIME, PLAY)
- Sub-module ts_pattern_ram: 2**PAT_AW x 18 simple dual-port RAM, single clock, registered read with 1-cycle latency, read-first; infers block or distributed RAM.
- The FSM, address counter and pass counter live in ts_tx_pattern.

## Test plan
- Reset release, no commands: tx_d=16'h50BC and tx_k=2'b01 every cycle; busy=0, pass_count=0.
- Load entries 0..3 = 16'h1000+i with k=0, length=3, loop=0, start at edge N: entries appear at N+2..N+5, idle at N+6, done=1 only at N+6, pass_count=1.
- length=0, loop=1, entry 0 = 16'hA5A5, run 10 cycles then stop: continuous A5A5 with no idle gap, pass_count increments every cycle, idle plus done follow the pass in progress.
- length=63, loop=1, stop mid-pass at entry 20: entries 21..63 complete, then idle; no partial pass is counted.
- Write entry 5 = 16'hBEEF during playback on the cycle it is read: the current pass shows the old value and the next pass shows 16'hBEEF. start asserted while busy has no effect.
- Reset asserted at entry 2 of a loop: idle on the next edge, busy=0, pass_count=0. A new start replays the original pattern, proving the RAM was preserved.
